// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register; optional perf counters with EXE_MEM_PERF_EN.
// Latency: one cycle. Backpressure: freeze holds every register, flush inserts a bubble and wins over freeze.
// Enables are stored already gated by validity so a bubble can never write memory or the register file.
module exe_mem_reg #(
  parameter int BIT_NUMBER = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [BIT_NUMBER-1:0] alu_result_in,
  input  logic [BIT_NUMBER-1:0] val_rm_in,
  input  logic [3:0]            dest_in,
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic [BIT_NUMBER-1:0] alu_result_out,
  output logic [BIT_NUMBER-1:0] val_rm_out,
  output logic [3:0]            dest_out,
  output logic                  fwd_valid
`ifdef EXE_MEM_PERF_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           retired_count
`endif
);

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } ctrl_t;

  typedef struct packed {
    logic [BIT_NUMBER-1:0] alu_result;
    logic [BIT_NUMBER-1:0] val_rm;
    logic [3:0]            dest;
  } data_t;

  ctrl_t ctrl_q;
  data_t data_q;
  ctrl_t ctrl_d;
  data_t data_d;
  logic  advance;

  assign advance = ~freeze & ~flush;

  // A load+store pair is illegal upstream; it is stored as-is, never arbitrated.
  always_comb begin
    ctrl_d.valid    = valid_in;
    ctrl_d.wb_en    = valid_in & wb_en_in;
    ctrl_d.mem_r_en = valid_in & mem_r_en_in;
    ctrl_d.mem_w_en = valid_in & mem_w_en_in;
    data_d.alu_result = alu_result_in;
    data_d.val_rm     = val_rm_in;
    data_d.dest       = dest_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (!freeze) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign valid_out      = ctrl_q.valid;
  assign wb_en_out      = ctrl_q.wb_en;
  assign mem_r_en_out   = ctrl_q.mem_r_en;
  assign mem_w_en_out   = ctrl_q.mem_w_en;
  assign alu_result_out = data_q.alu_result;
  assign val_rm_out     = data_q.val_rm;
  assign dest_out       = data_q.dest;

  // Load data only exists after MEM, so loads are never forwarded from here.
  assign fwd_valid = ctrl_q.valid & ctrl_q.wb_en & ~ctrl_q.mem_r_en;

`ifdef EXE_MEM_PERF_EN
  logic stall_hit;
  logic retire_hit;

  assign stall_hit  = freeze & ~flush & ctrl_q.valid;
  assign retire_hit = advance & ctrl_q.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles  <= '0;
      retired_count <= '0;
    end else begin
      if (stall_hit && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (retire_hit && retired_count != 16'hFFFF)
        retired_count <= retired_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed + randomized bench for exe_mem_reg against a slot-level reference model.
// Define EXE_MEM_PERF_EN to also exercise the stall/retire counters.
module tb_exe_mem_reg;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [W-1:0]  alu_result_in, val_rm_in;
  logic [3:0]    dest_in;
  logic          valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, fwd_valid;
  logic [W-1:0]  alu_result_out, val_rm_out;
  logic [3:0]    dest_out;
`ifdef EXE_MEM_PERF_EN
  logic [15:0]   stall_cycles, retired_count;
`endif

  exe_mem_reg #(.BIT_NUMBER(W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_result_out(alu_result_out),
    .val_rm_out(val_rm_out), .dest_out(dest_out), .fwd_valid(fwd_valid)
`ifdef EXE_MEM_PERF_EN
    , .stall_cycles(stall_cycles), .retired_count(retired_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: what instruction sits in the MEM slot, plus event counts.
  typedef struct {
    bit       valid;
    bit       wb, rd, wr;
    bit [W-1:0] alu, rm;
    bit [3:0] dest;
  } slot_t;

  slot_t m;
  int    m_stalls, m_retired;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m = '{default: 0};
    m_stalls  = 0;
    m_retired = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(valid_out), 32'(m.valid));
    check({tag, ".wb"},    32'(wb_en_out), 32'(m.valid && m.wb));
    check({tag, ".rd"},    32'(mem_r_en_out), 32'(m.valid && m.rd));
    check({tag, ".wr"},    32'(mem_w_en_out), 32'(m.valid && m.wr));
    check({tag, ".alu"},   alu_result_out, m.alu);
    check({tag, ".rm"},    val_rm_out, m.rm);
    check({tag, ".dest"},  32'(dest_out), 32'(m.dest));
    check({tag, ".fwd"},   32'(fwd_valid), 32'(m.valid && m.wb && !m.rd));
`ifdef EXE_MEM_PERF_EN
    check({tag, ".stalls"},  32'(stall_cycles), 32'(m_stalls > 65535 ? 65535 : m_stalls));
    check({tag, ".retired"}, 32'(retired_count), 32'(m_retired > 65535 ? 65535 : m_retired));
`endif
  endtask

  // Predict the slot after the coming edge from the current inputs.
  task automatic predict();
    if (freeze && !flush && m.valid) m_stalls++;
    if (!freeze && !flush && m.valid) m_retired++;
    if (flush) begin
      m.valid = 0; m.wb = 0; m.rd = 0; m.wr = 0;
    end else if (!freeze) begin
      if (valid_in && mem_r_en_in && mem_w_en_in)
        $display("note: illegal load+store pair captured (alu=%h)", alu_result_in);
      m.valid = valid_in;
      m.wb = valid_in && wb_en_in;
      m.rd = valid_in && mem_r_en_in;
      m.wr = valid_in && mem_w_en_in;
      m.alu = alu_result_in;
      m.rm = val_rm_in;
      m.dest = dest_in;
    end
  endtask

  task automatic step(input string tag);
    predict();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit wb, input bit rd, input bit wr,
                       input logic [W-1:0] alu, input logic [W-1:0] rm, input logic [3:0] d);
    valid_in = v; wb_en_in = wb; mem_r_en_in = rd; mem_w_en_in = wr;
    alu_result_in = alu; val_rm_in = rm; dest_in = d;
  endtask

  task automatic drive_random();
    bit [1:0] kind;
    kind = 2'($urandom_range(0, 2));
    drive(($urandom_range(0, 3) != 0), 1'($urandom), kind == 2'd1, kind == 2'd2,
          $urandom, $urandom, 4'($urandom));
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);
    model_reset();
    #3;
    check_all("por");
    #1 rst = 1'b1;
    step("first_bubble");

    // Load the slot, then assert reset between edges.
    drive(1, 1, 0, 1, 32'hA5A5_0001, 32'h0BAD_F00D, 4'd9);
    step("preload");
    rst = 1'b0;
    #2;
    model_reset();
    check_all("reset_async");
    #1 rst = 1'b1;
    drive(1, 0, 0, 0, 32'h0000_1234, 32'h0, 4'd5);
    step("post_reset");
    check("post_reset.alu_const", alu_result_out, 32'h0000_1234);
    check("post_reset.dest_const", 32'(dest_out), 32'd5);

    // Store captured, then frozen for three cycles while inputs churn.
    drive(1, 0, 0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'd2);
    step("store");
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step("freeze");
    end
    check("freeze.rm_const", val_rm_out, 32'hDEAD_BEEF);
    check("freeze.wr_const", 32'(mem_w_en_out), 32'd1);
`ifdef EXE_MEM_PERF_EN
    check("freeze.stall_cycles", 32'(stall_cycles), 32'd3);
`endif
    freeze = 1'b0;

    // Reset during a freeze discards the held instruction.
    freeze = 1'b1;
    rst = 1'b0;
    #2;
    model_reset();
    check_all("reset_in_freeze");
    #1 rst = 1'b1;
    step("freeze_after_reset");
    freeze = 1'b0;

    // Load held under freeze, then freeze+flush together.
    drive(1, 1, 1, 0, 32'h0000_4000, 32'h0, 4'd7);
    step("load");
    check("load.fwd_const", 32'(fwd_valid), 32'd0);
    freeze = 1'b1;
    drive_random();
    step("load_frozen");
    flush = 1'b1;
    step("flush_freeze");
    check("flush_freeze.valid_const", 32'(valid_out), 32'd0);
    check("flush_freeze.rd_const", 32'(mem_r_en_out), 32'd0);
    check("flush_freeze.alu_const", alu_result_out, 32'h0000_4000);
    freeze = 1'b0; flush = 1'b0;

    // Bubble with stray enables.
    drive(0, 1, 0, 1, 32'h1111_2222, 32'h3333_4444, 4'd3);
    step("bubble");
    check("bubble.wb_const", 32'(wb_en_out), 32'd0);
    check("bubble.wr_const", 32'(mem_w_en_out), 32'd0);
    check("bubble.fwd_const", 32'(fwd_valid), 32'd0);

    // Forwarding: ALU op forwards.
    drive(1, 1, 0, 0, 32'h0000_00AA, 32'h0, 4'd1);
    step("alu_op");
    check("alu_op.fwd_const", 32'(fwd_valid), 32'd1);

    // Illegal load+store pair is stored as-is.
    drive(1, 1, 1, 1, 32'h0000_0BB0, 32'h5, 4'd4);
    step("illegal");
    check("illegal.both_const", 32'({mem_r_en_out, mem_w_en_out}), 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      if (!(valid_in && mem_r_en_in && mem_w_en_in)) step("rand");
    end
    freeze = 1'b0; flush = 1'b0;

`ifdef EXE_MEM_PERF_EN
    // Drive the retire counter into saturation.
    drive(1, 1, 0, 0, 32'h0000_0077, 32'h0, 4'd6);
    for (int i = 0; i < 65537; i++) begin
      predict();
      @(posedge clk);
    end
    #1;
    check("sat.retired_const", 32'(retired_count), 32'h0000_FFFF);
    step("sat_hold1");
    step("sat_hold2");
    check("sat.hold_const", 32'(retired_count), 32'h0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
